gray_count_decoder: RTL
=======================

Name: gray_count_decoder

Overview:
- Consumer stage for the 4-bit gray code counter output; may sit in an unrelated or asynchronous clock domain.
- Resynchronizes the gray bus and converts it to binary.
- Classifies each accepted change as a +1 step, a -1 step, or an illegal multi-bit jump (glitch or skip).
- Feeds binary position, step pulses and error statistics to downstream logic.

Parameters:
WIDTH, 4, gray/binary bus width (>=2)
SYNC_STAGES, 2, synchronizer flop depth on gray_in (>=2)
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
gray_in  in  WIDTH  gray code value from counter; asynchronous to clk
clear_err  in  1  synchronous clear of err_count
bin_out  out  WIDTH  registered binary value of last accepted gray code
locked  out  1  high while in TRACK state
up  out  1  one-cycle pulse: accepted value = previous + 1 (mod 2^WIDTH)
down  out  1  one-cycle pulse: accepted value = previous - 1 (mod 2^WIDTH)
err  out  1  one-cycle pulse: illegal transition detected
err_count  out  ERR_W  saturating count of err pulses

Behaviour:
- Reset (async, immediate):
  - Sync chain, sample registers, bin_out, err_count: 0.
  - locked, up, down, err: 0.
  - State: ACQUIRE.
- Sync chain:
  - SYNC_STAGES flops clocked every cycle in all states.
  - s = last stage; s_d = s delayed one cycle.
- gray-to-binary: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. Pure combinational on registered values.
- FSM states: ACQUIRE, TRACK.
- ACQUIRE:
  - locked=0; no up/down pulses.
  - When s == s_d: prev <= s, bin_out <= gray2bin(s), move to TRACK. locked=1 from the next cycle.
  - Otherwise stay in ACQUIRE.
- TRACK (locked=1):
  - s == prev: no action.
  - popcount(s ^ prev) == 1:
    - prev <= s; bin_out <= gray2bin(s).
    - up=1 if gray2bin(s) == gray2bin(prev)+1 mod 2^WIDTH, else down=1. Exactly one of the two fires.
  - popcount(s ^ prev) > 1:
    - err=1; err_count increments, saturating at 2^ERR_W-1.
    - bin_out and prev hold; move to ACQUIRE.
- Latency (filter disabled): gray_in edge to bin_out/up/down registered = SYNC_STAGES+1 clk edges. Pulses coincide with the bin_out update.
- Wrap-around: gray 1000 -> 0000 (bin 15 -> 0) gives up; 0000 -> 1000 gives down.
- clear_err:
  - err_count <= 0.
  - If an err occurs in the same cycle, err_count <= 1 (error wins over clear for that event).
- Saturation: err pulse still fires at max count; count stays at max.
- Reset mid-operation: all outputs return to reset values asynchronously. Re-acquisition requires the stability rule again.

Optional Feature:
GRAY_DEC_FILTER_EN
- Defined:
  - In TRACK, a changed s is accepted only if s == s_d, i.e. stable for 2 consecutive cycles; single-cycle glitches are discarded silently.
  - Latency becomes SYNC_STAGES+2.
  - Multi-bit check applies only to the stable value.
- Undefined: changes are evaluated the cycle they appear at s, as above.

Test Plan:
- Reset, gray_in=0000 held -> after SYNC_STAGES+2 edges: locked=1, bin_out=0, no up/down/err; all outputs 0 while rst=1.
- Drive full up sequence 0000,0001,0011,...,1000,0000, one code per 8 clk -> 16 up pulses, bin_out 0..15 then 0, down=0, err=0.
- Drive the sequence in reverse from 0000 -> first code 1000 gives down with bin_out=15; 16 down pulses total.
- Locked at 0011 (bin 2), jump to 0110 (2 bits differ) -> err=1 one cycle, err_count=1, locked=0, bin_out stays 2. Hold 0110 -> relock with bin_out=4, no up pulse.
- Force 256 illegal jumps -> err_count=255 (saturated). Then assert clear_err with a simultaneous error -> err_count=1.
- With GRAY_DEC_FILTER_EN, locked at 0001: pulse 0011 for 1 clk then back to 0001 -> no up/down/err. Hold 0011 for 3 clk -> one up, bin_out=2, SYNC_STAGES+2 latency.

Source files
------------

// File: rtl/gray_count_decoder.sv
// gray_count_decoder: resynchronizes an asynchronous gray-coded counter bus,
// converts it to binary and classifies each accepted change as +1, -1 or an
// illegal multi-bit jump, with a saturating error counter.
// Optional build macro GRAY_DEC_FILTER_EN: in TRACK a changed value is only
// evaluated once it has been stable for two consecutive cycles.
module gray_count_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             locked,
    output logic             up,
    output logic             down,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {ACQUIRE, TRACK} state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0] s, s_d, prev;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev_nxt, bin_nxt, diff, bin_s, bin_inc;
    logic             up_nxt, down_nxt, err_nxt, eval, multi;
    logic [ERR_W-1:0] cnt_nxt;

    assign s      = sync[SYNC_STAGES-1];
    assign locked = (state == TRACK);

    // Synchronizer chain plus one extra delay stage for the stability compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            s_d  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], gray_in};
            s_d  <= s;
        end
    end

    assign diff    = s ^ prev;
    // More than one bit set: clearing the lowest set bit leaves something behind
    assign multi   = (diff & (diff - WIDTH'(1))) != '0;
    assign bin_s   = gray2bin(s);
    assign bin_inc = gray2bin(prev) + WIDTH'(1);

`ifdef GRAY_DEC_FILTER_EN
    assign eval = (s != prev) && (s == s_d);
`else
    assign eval = (s != prev);
`endif

    // Next-state, accepted value, pulse and error-counter decode
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        bin_nxt   = bin_out;
        up_nxt    = 1'b0;
        down_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            ACQUIRE: begin
                if (s == s_d) begin
                    prev_nxt  = s;
                    bin_nxt   = bin_s;
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (eval) begin
                    if (multi) begin
                        err_nxt   = 1'b1;
                        state_nxt = ACQUIRE;
                    end else begin
                        prev_nxt = s;
                        bin_nxt  = bin_s;
                        if (bin_s == bin_inc) up_nxt = 1'b1;
                        else                  down_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ACQUIRE;
        endcase

        // An error in the same cycle as a clear restarts the count at one
        cnt_nxt = err_count;
        if (err_nxt) begin
            if (clear_err)              cnt_nxt = ERR_W'(1);
            else if (err_count != ERR_MAX) cnt_nxt = err_count + ERR_W'(1);
        end else if (clear_err) begin
            cnt_nxt = '0;
        end
    end

    // State, accepted sample, registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACQUIRE;
            prev      <= '0;
            bin_out   <= '0;
            up        <= 1'b0;
            down      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            bin_out   <= bin_nxt;
            up        <= up_nxt;
            down      <= down_nxt;
            err       <= err_nxt;
            err_count <= cnt_nxt;
        end
    end

endmodule
